// File: rtl/leiwand_rv32_wb_timer_if.sv
// ---------------------------------------------------------------------------
// leiwand_rv32_wb_timer_if
// Wishbone pipelined bus bundle between a core-side initiator and the machine
// timer responder.
//   addr     word address of the register (initiator -> responder)
//   data_in  write data                   (initiator -> responder)
//   we       1 = write, 0 = read          (initiator -> responder)
//   stb      strobe, already address-decoded by the SoC
//   cyc      bus cycle active
//   data_out read data, 0 outside a read ack cycle (responder -> initiator)
//   ack      one-cycle acknowledge                 (responder -> initiator)
//   stall    responder cannot accept a request     (responder -> initiator)
// ---------------------------------------------------------------------------
interface leiwand_rv32_wb_timer_if #(
    parameter int MEM_WIDTH = 32,
    parameter int ADDR_BITS = 3
);
    logic [ADDR_BITS-1:0] addr;
    logic [MEM_WIDTH-1:0] data_in;
    logic [MEM_WIDTH-1:0] data_out;
    logic                 we;
    logic                 stb;
    logic                 cyc;
    logic                 ack;
    logic                 stall;

    modport master (
        output addr, data_in, we, stb, cyc,
        input  data_out, ack, stall
    );

    modport slave (
        input  addr, data_in, we, stb, cyc,
        output data_out, ack, stall
    );
endinterface

// File: rtl/leiwand_rv32_wb_timer.sv
// ---------------------------------------------------------------------------
// leiwand_rv32_wb_timer
// Memory-mapped RISC-V machine timer (mtime / mtimecmp) behind a Wishbone
// pipelined responder, with a prescaler and a registered level interrupt.
//   clk    system clock, all logic on the rising edge
//   reset  synchronous, active-high reset
//   bus    Wishbone slave bundle (addr, data_in, we, stb, cyc / data_out,
//          ack, stall); data_out, ack and stall are 0 whenever this block is
//          not acknowledging, so they can be OR-combined with other responders
//   irq    timer interrupt: irq_en && (mtime >= mtimecmp), registered
// Register map (word address): 0 MTIME_LO, 1 MTIME_HI (reads the hi shadow),
// 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL {irq_en, count_en}, 5 PRESCALER,
// 6..7 unmapped (read 0, writes ignored, still acknowledged).
// ---------------------------------------------------------------------------
module leiwand_rv32_wb_timer #(
    parameter int MEM_WIDTH = 32,
    parameter int ADDR_BITS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    leiwand_rv32_wb_timer_if.slave  bus,
    output logic                    irq
);
    localparam int NUM_REGS = 6;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t               state_q;
    logic                 ack_q;
    logic                 stall_q;
    logic [MEM_WIDTH-1:0] dout_q;
    logic                 irq_q;

    logic [63:0]          mtime_q,    mtime_d;
    logic [63:0]          mtimecmp_q, mtimecmp_d;
    logic [1:0]           ctrl_q,     ctrl_d;
    logic [31:0]          presc_q,    presc_d;
    logic [31:0]          pcnt_q,     pcnt_d;
    logic [31:0]          shadow_q,   shadow_d;

    logic                 accept;
    logic                 wr;
    logic                 rd_lo;
    logic                 tick;
    logic [NUM_REGS-1:0]  wr_sel;
    logic [MEM_WIDTH-1:0] rdata;

    // The FSM state is the stall flag: only IDLE can take a new request.
    assign accept = bus.cyc && bus.stb && (state_q == IDLE);
    assign wr     = accept && bus.we;
    assign rd_lo  = accept && !bus.we && (bus.addr == ADDR_BITS'(0));

    // One write strobe per mapped register.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr && (bus.addr == ADDR_BITS'(gi));
        end
    endgenerate

    // Prescale tick: the counter has reached PRESCALER while counting.
    assign tick = ctrl_q[0] && (pcnt_q == presc_q);

    always_comb begin
        rdata = '0;
        case (bus.addr)
            ADDR_BITS'(0): rdata = mtime_q[31:0];
            ADDR_BITS'(1): rdata = shadow_q;
            ADDR_BITS'(2): rdata = mtimecmp_q[31:0];
            ADDR_BITS'(3): rdata = mtimecmp_q[63:32];
            ADDR_BITS'(4): rdata = {30'b0, ctrl_q};
            ADDR_BITS'(5): rdata = presc_q;
            default:       rdata = '0;
        endcase
    end

    always_comb begin
        pcnt_d = pcnt_q;
        if (ctrl_q[0]) begin
            pcnt_d = tick ? 32'd0 : pcnt_q + 32'd1;
        end
        if (wr_sel[5]) begin
            pcnt_d = 32'd0;
        end

        // A write to either mtime half replaces the increment for that cycle,
        // so no carry can leak into the half that was not written.
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr_sel[0]) begin
            mtime_d = {mtime_q[63:32], bus.data_in};
        end
        if (wr_sel[1]) begin
            mtime_d = {bus.data_in, mtime_q[31:0]};
        end

        mtimecmp_d = mtimecmp_q;
        if (wr_sel[2]) begin
            mtimecmp_d[31:0] = bus.data_in;
        end
        if (wr_sel[3]) begin
            mtimecmp_d[63:32] = bus.data_in;
        end

        ctrl_d  = wr_sel[4] ? bus.data_in[1:0] : ctrl_q;
        presc_d = wr_sel[5] ? bus.data_in : presc_q;

        // Reading the low word freezes the high word for a coherent 64-bit read.
        shadow_d = rd_lo ? mtime_q[63:32] : shadow_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            stall_q    <= 1'b0;
            dout_q     <= '0;
            irq_q      <= 1'b0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            ctrl_q     <= 2'b00;
            presc_q    <= 32'd0;
            pcnt_q     <= 32'd0;
            shadow_q   <= 32'd0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_q     <= ctrl_d;
            presc_q    <= presc_d;
            pcnt_q     <= pcnt_d;
            shadow_q   <= shadow_d;
            irq_q      <= ctrl_q[1] && (mtime_q >= mtimecmp_q);

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= RESP;
                        ack_q   <= 1'b1;
                        stall_q <= 1'b1;
                        dout_q  <= bus.we ? '0 : rdata;
                    end
                end
                RESP: begin
                    // Ack pulses even if cyc dropped; the initiator ignores it.
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    stall_q <= 1'b0;
                    dout_q  <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    stall_q <= 1'b0;
                    dout_q  <= '0;
                end
            endcase
        end
    end

    assign bus.ack      = ack_q;
    assign bus.stall    = stall_q;
    assign bus.data_out = dout_q;
    assign irq          = irq_q;
endmodule

// File: doc/leiwand_rv32_wb_timer.md
Name: leiwand_rv32_wb_timer

Overview:
Wishbone pipelined responder: a memory-mapped RISC-V machine timer (mtime/mtimecmp) with prescaler and level interrupt output. It sits on the core's Wishbone bus beside the internal SRAM/ROM, selected by the SoC address decode through `stb`. Its `data_out`, `ack` and `stall` are OR-combined with the other responders, so every one of them must be 0 whenever the timer is not acknowledging.

Parameters:
MEM_WIDTH, 32, Wishbone data width; only 32 is supported.
ADDR_BITS, 3, word-address width (byte address bits [ADDR_BITS+1:2]).

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
addr  input  ADDR_BITS  word address of the register
data_in  input  MEM_WIDTH  write data from the initiator
data_out  output  MEM_WIDTH  read data; 0 except in an ack cycle of a read
we  input  1  1 = write, 0 = read
stb  input  1  strobe, already qualified by the SoC address decode
ack  output  1  one-cycle acknowledge
cyc  input  1  bus cycle active
stall  output  1  responder cannot accept a new request this cycle
irq  output  1  timer interrupt, level, registered

Behaviour:
- Reset values: ack=0, stall=0, data_out=0, irq=0; mtime=0; mtimecmp=64'hFFFF_FFFF_FFFF_FFFF; ctrl=0; prescaler=0; prescale counter=0; hi shadow=0.
- Register map (word addr):
  - 0 MTIME_LO (rw).
  - 1 MTIME_HI (rw; a read returns the hi shadow).
  - 2 MTIMECMP_LO (rw).
  - 3 MTIMECMP_HI (rw).
  - 4 CTRL (rw): bit0 count_en, bit1 irq_en; other bits read 0.
  - 5 PRESCALER (rw, 32 bit).
  - 6, 7 unmapped: read 0, write ignored, still acked.
- Handshake FSM, two states:
  - IDLE: stall=0. A request is accepted when cyc && stb && !stall; the FSM then goes to RESP.
  - RESP: ack=1 and stall=1 for exactly one cycle, then back to IDLE.
  - Latency is one cycle from accept to ack. Throughput is at most one request per 2 cycles; a stb asserted in RESP is stalled and must be held by the initiator.
- Read data is captured at accept and driven on data_out only in the RESP cycle; data_out=0 otherwise.
- Writes take effect at the accept edge, so they are visible to a read accepted 2 cycles later.
- A cyc drop while in RESP: ack still pulses (the initiator ignores it); no other side effect.
- 64-bit read coherency: a read of MTIME_LO returns mtime[31:0] and copies mtime[63:32] into the hi shadow on the same edge. A MTIME_HI read returns the shadow, not the live value.
- Counting:
  - When count_en=1, the prescale counter increments every cycle.
  - When counter==PRESCALER, the counter clears and mtime increments by 1. PRESCALER=0 means mtime increments every cycle.
  - When count_en=0, both mtime and the counter hold.
  - mtime wraps from 2^64-1 to 0; there is no flag.
  - A write to PRESCALER clears the prescale counter.
- Simultaneous MTIME_LO/HI write and increment: the written half takes data_in and the other half holds, i.e. no increment that cycle and no carry.
- irq is registered every cycle as irq <= irq_en && (mtime >= mtimecmp), using unsigned 64-bit compare on the current register values. It is visible 1 cycle after the condition holds.
- irq is cleared only by raising mtimecmp, lowering mtime, or clearing irq_en.
- Reset mid-transaction: the FSM returns to IDLE and a pending ack is dropped (ack=0 next cycle); all registers take their reset values.

Test Plan:
1. Reset, then read addr 3 -> ack exactly 1 cycle after accept, data_out=FFFF_FFFF; data_out=0 in all other cycles; stall=1 only in the ack cycle.
2. Write PRESCALER=0, CTRL=1; wait 10 cycles; read LO then HI -> LO within the expected count ±2, HI=0. Set mtime=0000_0000_FFFF_FFFE, keep counting, read LO then HI -> the HI value matches the shadow captured at the LO read (carry handled coherently).
3. PRESCALER=3, CTRL=1, mtime=0 -> mtime advances by 1 every 4 cycles; after 40 cycles mtime=10.
4. mtimecmp=20, CTRL=3, mtime=0 -> irq rises 1 cycle after mtime reaches 20. Write MTIMECMP_HI=1 -> irq falls 1 cycle after the write is accepted.
5. Back-to-back stb held for 3 writes -> each write is accepted every 2nd cycle, stall=1 in each ack cycle, exactly 3 acks. Read of addr 6 -> ack with data 0.
6. Assert reset in the RESP cycle -> ack=0 next cycle, irq=0, mtime=0, mtimecmp=all ones.
